mips_decode_stage: RTL and testbench
====================================

// Module: mips_decode_stage
// PURPOSE
//  Registered instruction-decode stage for the MIPS core: splits a fetched word into register
//  addresses, extended immediate and jump field, and decodes the opcode into the control bundle.
//  Generalised successor of the combinational control/field splitter: parametrised widths,
//  valid/ready handshake, flush, and load-use hazard bubble insertion.
//  Sits between fetch (upstream) and register-read/execute (downstream).
// PARAMETERS
//  PC_W       32  width of program counter carried with the instruction
//  DATA_W     32  width of extended immediate (>=16)
//  HAZARD_EN  1   1 = detect load-use hazard and insert one bubble; 0 = never stall for hazards
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  in_valid    in   1       upstream instruction valid
//  in_ready    out  1       stage can accept in_instr this cycle
//  in_instr    in   32      instruction word
//  in_pc       in   PC_W    PC of in_instr
//  flush       in   1       kill contents (taken branch/jump)
//  out_valid   out  1       decoded bundle valid
//  out_ready   in   1       downstream accepts bundle
//  out_pc      out  PC_W    PC of decoded instruction
//  rs,rt,rd    out  5 each  instr[25:21],[20:16],[15:11]
//  imm_ext     out  DATA_W  instr[15:0] sign- or zero-extended per opcode
//  addr_j      out  26      instr[25:0]
//  reg_dst,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,j  out 1 each  control bits
//  alu_op      out  2       00 add, 01 sub (beq), 10 funct (R-type), 11 logical-imm
//  illegal     out  1       opcode not in decode table
//  hazard      out  1       combinational: load-use bubble being inserted this cycle
// BEHAVIOUR
//  - Reset (async, while high): out_valid=0, every registered output 0; in_ready=0 while reset high.
//  - Single output register; latency 1 cycle from in_valid&in_ready to out_valid.
//  - in_ready = (!out_valid | out_ready) & !flush & !hazard.
//  - Load: in_valid&in_ready -> register all fields, out_valid<=1 next edge.
//  - Drain: out_valid&out_ready with no load -> out_valid<=0.
//  - Hold: out_valid&!out_ready -> all outputs stable (no change on any output).
//  - Decode table (opcode -> controls; unlisted bits 0):
//      000000 R:    reg_dst,reg_write, alu_op=10
//      100011 lw:   alu_src,mem_to_reg,reg_write,mem_read, alu_op=00, sign-ext
//      101011 sw:   alu_src,mem_write, alu_op=00, sign-ext
//      000100 beq:  branch, alu_op=01, sign-ext
//      001000 addi: alu_src,reg_write, alu_op=00, sign-ext
//      001100/001101 andi/ori: alu_src,reg_write, alu_op=11, zero-ext
//      000010 j:    j
//      other: all controls 0, illegal=1 (bundle still emitted, out_valid=1).
//  - imm_ext: sign-ext replicates bit15 to DATA_W; zero-ext pads 0; R-type/j use sign-ext value.
//  - Hazard (HAZARD_EN=1): hazard = out_valid & mem_read & rt!=0 & in_valid &
//    (in.rs==rt | (in reads rt: R-type, beq, sw) & in.rt==rt). While hazard: in_ready=0;
//    on out_ready edge the register loads a bubble (out_valid<=0); next cycle hazard clears
//    and the instruction loads normally. Net: exactly one bubble cycle.
//  - Flush: highest priority. On edge with flush=1: out_valid<=0, input not accepted
//    (in_ready=0), hazard state irrelevant. Flush together with out_ready: bundle counts as consumed.
//  - Simultaneous drain+load: allowed, register overwritten, out_valid stays 1 (full throughput).
//  - rt=0 never triggers hazard; illegal opcode in register never triggers hazard (mem_read=0).
// STRUCTURE
//  - Package mips_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI,
//    OP_ORI, OP_J), ALU_OP codes, control-bundle field widths.
//  - One sub-module: mips_control_decoder (pure combinational opcode -> controls + ext mode
//    + illegal). Top holds register, handshake, hazard and flush logic.
// TESTING
//  1 Reset mid-stream: reset high with out_valid=1 -> out_valid=0, all outputs 0 immediately.
//  2 Back-to-back: 0x8C820004 (lw $2,4($4)) then 0x00A63820 (add $7,$5,$6), out_ready=1 ->
//    one per cycle; lw: mem_read=1,imm_ext=4; add: reg_dst=1,alu_op=10,rd=7.
//  3 Load-use: lw $2,... then 0x00423020 (add $6,$2,$2) -> hazard=1, one out_valid=0 cycle, then add.
//  4 Backpressure: out_ready=0 for 3 cycles -> in_ready=0, outputs bit-stable; release -> next loads.
//  5 Extension: 0x2001FFFF addi -> imm_ext=0xFFFFFFFF; 0x3421FFFF ori -> 0x0000FFFF, alu_op=11.
//  6 Flush+illegal: opcode 111111 -> illegal=1, controls 0; flush with in_valid=1 -> in_ready=0,
//    out_valid=0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the MIPS decode stage.
package mips_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPC_W    = 6;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;
    localparam int ADDR_J_W = 26;
    localparam int ALU_OP_W = 2;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_LOGIC = 2'b11;

    typedef struct packed {
        logic                reg_dst;
        logic                branch;
        logic                mem_read;
        logic                mem_to_reg;
        logic                mem_write;
        logic                alu_src;
        logic                reg_write;
        logic                j;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    // Instructions whose rt field is a source operand (not a destination).
    function automatic logic reads_rt(input logic [OPC_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_control_decoder.sv
// Pure combinational opcode decoder: control bundle, extension mode, illegal flag.
module mips_control_decoder
    import mips_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output ctrl_t            o_ctrl,
    output logic             o_zero_ext,
    output logic             o_illegal
);

    // Opcode table; anything not listed decodes to no-op controls and flags illegal.
    always_comb begin
        o_ctrl     = '0;
        o_zero_ext = 1'b0;
        o_illegal  = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
            end
            OP_ANDI, OP_ORI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_LOGIC;
                o_zero_ext       = 1'b1;
            end
            OP_J: begin
                o_ctrl.j = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_decode_stage.sv
// Registered decode stage: field split, control decode, valid/ready, flush and
// load-use bubble insertion.
module mips_decode_stage
    import mips_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int HAZARD_EN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     out_pc,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [DATA_W-1:0]   imm_ext,
    output logic [ADDR_J_W-1:0] addr_j,
    output logic                reg_dst,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_to_reg,
    output logic                mem_write,
    output logic                alu_src,
    output logic                reg_write,
    output logic                j,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic                hazard
);

    logic [OPC_W-1:0]  w_opcode;
    logic [REG_W-1:0]  w_in_rs;
    logic [REG_W-1:0]  w_in_rt;
    logic [IMM_W-1:0]  w_imm16;
    logic [DATA_W-1:0] w_imm_ext;
    ctrl_t             w_ctrl;
    logic              w_zero_ext;
    logic              w_illegal;
    logic              w_hazard_raw;
    logic              w_load;

    logic                r_valid;
    logic [PC_W-1:0]     r_pc;
    logic [REG_W-1:0]    r_rs;
    logic [REG_W-1:0]    r_rt;
    logic [REG_W-1:0]    r_rd;
    logic [DATA_W-1:0]   r_imm_ext;
    logic [ADDR_J_W-1:0] r_addr_j;
    ctrl_t               r_ctrl;
    logic                r_illegal;

    assign w_opcode = in_instr[31:26];
    assign w_in_rs  = in_instr[25:21];
    assign w_in_rt  = in_instr[20:16];
    assign w_imm16  = in_instr[15:0];

    mips_control_decoder u_ctrl_dec (
        .i_opcode   (w_opcode),
        .o_ctrl     (w_ctrl),
        .o_zero_ext (w_zero_ext),
        .o_illegal  (w_illegal)
    );

    // R-type and j carry the sign-extended value; only andi/ori zero-extend.
    assign w_imm_ext = w_zero_ext ? {{(DATA_W-IMM_W){1'b0}}, w_imm16}
                                  : {{(DATA_W-IMM_W){w_imm16[IMM_W-1]}}, w_imm16};

    // A load sitting in the register whose destination the incoming instruction reads.
    assign w_hazard_raw = r_valid & r_ctrl.mem_read & (r_rt != '0) & in_valid &
                          ((w_in_rs == r_rt) | (reads_rt(w_opcode) & (w_in_rt == r_rt)));
    assign hazard       = (HAZARD_EN != 0) ? w_hazard_raw : 1'b0;

    assign in_ready = ~reset & (~r_valid | out_ready) & ~flush & ~hazard;
    assign w_load   = in_valid & in_ready;

    // Output register: flush kills, load overwrites, otherwise a consumed bundle
    // (including the hazard bubble) empties the stage; stalled bundles hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_imm_ext <= '0;
            r_addr_j  <= '0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_pc      <= in_pc;
            r_rs      <= w_in_rs;
            r_rt      <= w_in_rt;
            r_rd      <= in_instr[15:11];
            r_imm_ext <= w_imm_ext;
            r_addr_j  <= in_instr[25:0];
            r_ctrl    <= w_ctrl;
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_pc     = r_pc;
    assign rs         = r_rs;
    assign rt         = r_rt;
    assign rd         = r_rd;
    assign imm_ext    = r_imm_ext;
    assign addr_j     = r_addr_j;
    assign reg_dst    = r_ctrl.reg_dst;
    assign branch     = r_ctrl.branch;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign mem_write  = r_ctrl.mem_write;
    assign alu_src    = r_ctrl.alu_src;
    assign reg_write  = r_ctrl.reg_write;
    assign j          = r_ctrl.j;
    assign alu_op     = r_ctrl.alu_op;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: directed scenarios followed by random traffic,
// all checked against an instruction-level reference model.
module tb_mips_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext;
    logic [25:0] addr_j;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, j;
    logic [1:0]  alu_op;
    logic        illegal;
    logic        hazard;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the instruction currently held by the stage.
    bit           m_valid = 1'b0;
    logic [31:0]  m_instr = '0;
    logic [127:0] m_b     = '0;
    logic [127:0] snap;

    mips_decode_stage #(.PC_W(32), .DATA_W(32), .HAZARD_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .rs(rs), .rt(rt), .rd(rd),
        .imm_ext(imm_ext), .addr_j(addr_j), .reg_dst(reg_dst), .branch(branch),
        .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .alu_src(alu_src), .reg_write(reg_write), .j(j), .alu_op(alu_op),
        .illegal(illegal), .hazard(hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Expected bundle for an instruction, straight from the opcode table.
    // Control order: reg_dst branch mem_read mem_to_reg mem_write alu_src reg_write j.
    function automatic logic [127:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        logic [15:0] i16;
        logic [31:0] ext;
        logic [7:0]  ctl;
        logic [1:0]  alu;
        logic        ill;
        i16 = ins[15:0];
        ext = {{16{i16[15]}}, i16};
        ctl = 8'b0;
        alu = 2'd0;
        ill = 1'b0;
        case (ins[31:26])
            6'h00: begin ctl = 8'b1000_0010; alu = 2'd2; end
            6'h23: ctl = 8'b0011_0110;
            6'h2B: ctl = 8'b0000_1100;
            6'h04: begin ctl = 8'b0100_0000; alu = 2'd1; end
            6'h08: ctl = 8'b0000_0110;
            6'h0C, 6'h0D: begin ctl = 8'b0000_0110; alu = 2'd3; ext = {16'h0, i16}; end
            6'h02: ctl = 8'b0000_0001;
            default: ill = 1'b1;
        endcase
        return {12'b0, pc, ins[25:21], ins[20:16], ins[15:11], ext, ins[25:0], ctl, alu, ill};
    endfunction

    function automatic logic [127:0] dut_bundle();
        return {12'b0, out_pc, rs, rt, rd, imm_ext, addr_j, reg_dst, branch, mem_read,
                mem_to_reg, mem_write, alu_src, reg_write, j, alu_op, illegal};
    endfunction

    function automatic bit src_rt(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h04) || (op == 6'h2B);
    endfunction

    // One clock: check combinational handshake mid-cycle, advance model, check registers.
    task automatic cycle(input string tag);
        bit exp_haz, exp_rdy, acc;
        #3;
        exp_haz = m_valid && (m_instr[31:26] == 6'h23) && (m_instr[20:16] != 5'd0) && in_valid &&
                  ((in_instr[25:21] == m_instr[20:16]) ||
                   (src_rt(in_instr[31:26]) && (in_instr[20:16] == m_instr[20:16])));
        exp_rdy = !reset && (!m_valid || out_ready) && !flush && !exp_haz;
        chk({tag, " hazard"}, hazard, exp_haz);
        chk({tag, " in_ready"}, in_ready, exp_rdy);
        acc = in_valid && exp_rdy;
        @(posedge clk);
        if (flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_instr = in_instr;
            m_b     = ref_decode(in_instr, in_pc);
        end else if (out_ready) m_valid = 1'b0;
        #1;
        chk({tag, " out_valid"}, out_valid, m_valid);
        if (m_valid) chk({tag, " bundle"}, dut_bundle(), m_b);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [10];
        logic [31:0] w;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h3F, 6'h23};
        w = $urandom;
        w[31:26] = ops[$urandom_range(0, 9)];
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset bundle", dut_bundle(), 128'd0);
        chk("reset in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset mid-stream: fill the stage and stall it, then reset asynchronously.
        in_valid = 1'b1; in_instr = 32'h2001_1234; in_pc = 32'h40;
        cycle("fill");
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        m_valid = 1'b0; m_b = '0;
        chk("midreset out_valid", out_valid, 1'b0);
        chk("midreset bundle", dut_bundle(), 128'd0);
        chk("midreset in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Back-to-back lw then add at full throughput.
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'h8C82_0004; in_pc = 32'h100;
        cycle("b2b lw");
        chk("b2b lw mem_read", mem_read, 1'b1);
        chk("b2b lw imm_ext", imm_ext, 32'd4);
        in_instr = 32'h00A6_3820; in_pc = 32'h104;
        cycle("b2b add");
        chk("b2b add reg_dst", reg_dst, 1'b1);
        chk("b2b add alu_op", alu_op, 2'b10);
        chk("b2b add rd", rd, 5'd7);

        // Load-use: add $6,$2,$2 right after lw $2.
        in_instr = 32'h8C82_0004; in_pc = 32'h200;
        cycle("luse lw");
        in_instr = 32'h0042_3020; in_pc = 32'h204;
        #3;
        chk("luse hazard asserted", hazard, 1'b1);
        #1;
        cycle("luse bubble");
        chk("luse bubble valid", out_valid, 1'b0);
        cycle("luse add");
        chk("luse add rd", rd, 5'd6);
        in_valid = 1'b0;
        cycle("luse drain");

        // rt=0 load never stalls a consumer of $0.
        in_valid = 1'b1; in_instr = 32'h8C00_0004; in_pc = 32'h300;
        cycle("rt0 lw");
        in_instr = 32'h0000_0020; in_pc = 32'h304;
        cycle("rt0 add");

        // Backpressure: three stalled cycles, bundle must stay bit-stable.
        in_instr = 32'h2003_0011; in_pc = 32'h400;
        cycle("bp load");
        snap = dut_bundle();
        out_ready = 1'b0; in_instr = 32'h2004_0022; in_pc = 32'h404;
        for (int k = 0; k < 3; k++) begin
            cycle("bp stall");
            chk("bp stable", dut_bundle(), snap);
        end
        out_ready = 1'b1;
        cycle("bp release");
        chk("bp next pc", out_pc, 32'h404);

        // Extension modes.
        in_instr = 32'h2001_FFFF; in_pc = 32'h500;
        cycle("ext addi");
        chk("ext addi imm", imm_ext, 32'hFFFF_FFFF);
        in_instr = 32'h3421_FFFF; in_pc = 32'h504;
        cycle("ext ori");
        chk("ext ori imm", imm_ext, 32'h0000_FFFF);
        chk("ext ori alu_op", alu_op, 2'b11);

        // Illegal opcode, then flush with a valid input waiting.
        in_instr = 32'hFC00_0000; in_pc = 32'h600;
        cycle("illegal");
        chk("illegal flag", illegal, 1'b1);
        chk("illegal ctl", {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, j, alu_op}, 10'd0);
        out_ready = 1'b0; flush = 1'b1; in_instr = 32'h2001_0001; in_pc = 32'h604;
        cycle("flush");
        chk("flush out_valid", out_valid, 1'b0);
        flush = 1'b0; out_ready = 1'b1;

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
